// File: rtl/adder_issue_ctrl.sv
// Operand issue / result collection around a registered adder.
// Ports: i_clk/i_rst, operand in (i_valid/o_ready/i_op*),
//   adder side (o_add_op*, i_add_sum/co), result out
//   (o_res_valid/i_res_ready/o_res_sum/co), o_busy.
module adder_issue_ctrl #(
   parameter int p_width  = 32,
   parameter int p_depth  = 4,
   parameter int p_rdepth = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [p_width-1:0] i_op1,
   input  logic [p_width-1:0] i_op2,
   output logic [p_width-1:0] o_add_op1,
   output logic [p_width-1:0] o_add_op2,
   input  logic [p_width-1:0] i_add_sum,
   input  logic               i_add_co,
   output logic               o_res_valid,
   input  logic               i_res_ready,
   output logic [p_width-1:0] o_res_sum,
   output logic               o_res_co,
   output logic               o_busy
);

   localparam int AW = $clog2(p_depth);
   localparam int RW = $clog2(p_rdepth);
   localparam int CW = $clog2(p_rdepth + 1);

   localparam logic [AW:0]   OP_ONE   = 1;
   localparam logic [RW:0]   RES_ONE  = 1;
   localparam logic [CW-1:0] CRED_ONE = 1;
   localparam logic [CW-1:0] CRED_MAX = CW'(p_rdepth);

   logic [p_width-1:0] op1_mem_q [p_depth];
   logic [p_width-1:0] op2_mem_q [p_depth];
   logic [p_width:0]   res_mem_q [p_rdepth];

   logic [AW:0]   op_wptr_q, op_wptr_d;
   logic [AW:0]   op_rptr_q, op_rptr_d;
   logic [RW:0]   res_wptr_q, res_wptr_d;
   logic [RW:0]   res_rptr_q, res_rptr_d;
   logic [CW-1:0] credits_q, credits_d;
   logic          issue_q;

   logic          op_empty, op_full, res_empty;
   logic          push, issue, res_pop;
   logic [p_width:0] res_head;

   assign op_empty = (op_wptr_q == op_rptr_q);
   assign op_full  = (op_wptr_q[AW] != op_rptr_q[AW]) &&
                     (op_wptr_q[AW-1:0] == op_rptr_q[AW-1:0]);
   assign res_empty = (res_wptr_q == res_rptr_q);

   assign push    = i_valid && !op_full;
   // An issue reserves a result slot; no credit, no issue.
   assign issue   = !op_empty && (credits_q != '0);
   assign res_pop = !res_empty && i_res_ready;

   assign res_head = res_mem_q[res_rptr_q[RW-1:0]];

   assign o_ready     = !op_full;
   assign o_add_op1   = issue ? op1_mem_q[op_rptr_q[AW-1:0]] : '0;
   assign o_add_op2   = issue ? op2_mem_q[op_rptr_q[AW-1:0]] : '0;
   assign o_res_valid = !res_empty;
   assign o_res_sum   = res_empty ? '0 : res_head[p_width-1:0];
   assign o_res_co    = res_empty ? 1'b0 : res_head[p_width];
   assign o_busy      = !op_empty || issue_q || !res_empty;

   always_comb begin
      op_wptr_d  = op_wptr_q;
      op_rptr_d  = op_rptr_q;
      res_wptr_d = res_wptr_q;
      res_rptr_d = res_rptr_q;
      credits_d  = credits_q;
      if (push)    op_wptr_d  = op_wptr_q + OP_ONE;
      if (issue)   op_rptr_d  = op_rptr_q + OP_ONE;
      if (issue_q) res_wptr_d = res_wptr_q + RES_ONE;
      if (res_pop) res_rptr_d = res_rptr_q + RES_ONE;
      if (issue && !res_pop)
         credits_d = credits_q - CRED_ONE;
      else if (!issue && res_pop)
         credits_d = credits_q + CRED_ONE;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         op_wptr_q  <= '0;
         op_rptr_q  <= '0;
         res_wptr_q <= '0;
         res_rptr_q <= '0;
         credits_q  <= CRED_MAX;
         issue_q    <= 1'b0;
      end else begin
         op_wptr_q  <= op_wptr_d;
         op_rptr_q  <= op_rptr_d;
         res_wptr_q <= res_wptr_d;
         res_rptr_q <= res_rptr_d;
         credits_q  <= credits_d;
         issue_q    <= issue;
      end
   end

   // Storage needs no reset: reads are gated by the empty flags.
   always_ff @(posedge i_clk) begin
      if (push) begin
         op1_mem_q[op_wptr_q[AW-1:0]] <= i_op1;
         op2_mem_q[op_wptr_q[AW-1:0]] <= i_op2;
      end
      // Adder output belongs to last cycle's issue.
      if (issue_q)
         res_mem_q[res_wptr_q[RW-1:0]] <= {i_add_co, i_add_sum};
   end

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Scoreboard bench for adder_issue_ctrl with a registered adder model.
// Directed vectors; monitor pops expected results on each result handshake.
module tb_adder_issue_ctrl;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_op1, i_op2;
   logic [31:0] o_add_op1, o_add_op2;
   logic [31:0] add_sum;
   logic        add_co;
   logic        o_res_valid;
   logic        i_res_ready;
   logic [31:0] o_res_sum;
   logic        o_res_co;
   logic        o_busy;

   int checks = 0;
   int errors = 0;
   int run = 0;
   int max_run = 0;
   logic stream_on = 1'b0;
   logic ready_drop = 1'b0;
   logic [32:0] exp_q [$];

   logic [31:0] va [10];
   logic [31:0] vb [10];
   logic [32:0] vs [10];

   always #5 clk = ~clk;

   adder_issue_ctrl #(.p_width(32), .p_depth(4), .p_rdepth(4)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_op1(i_op1), .i_op2(i_op2),
      .o_add_op1(o_add_op1), .o_add_op2(o_add_op2),
      .i_add_sum(add_sum), .i_add_co(add_co),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
      .o_res_sum(o_res_sum), .o_res_co(o_res_co),
      .o_busy(o_busy)
   );

   // Registered ripple-carry adder model sharing the reset.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) {add_co, add_sum} <= '0;
      else {add_co, add_sum} <= {1'b0, o_add_op1} + {1'b0, o_add_op2};
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (dut.credits_q > 3'd4) begin
         errors++;
         $display("FAIL credit_range: got %0d expected <= 4", dut.credits_q);
      end
      run = o_res_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (stream_on && !o_ready) ready_drop = 1'b1;
      if (!i_rst && o_res_valid && i_res_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stale_result: got %h expected none",
                     {o_res_co, o_res_sum});
         end else begin
            chk("result", {31'd0, o_res_co, o_res_sum}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] s);
      int n = 0;
      i_valid = 1'b1;
      i_op1 = a;
      i_op2 = b;
      while (!o_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got o_ready=0 expected 1");
      end else begin
         @(posedge clk);
         exp_q.push_back(s);
         #1;
      end
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || o_busy) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0",
                  exp_q.size());
      end
   endtask

   initial begin
      va[0] = 32'h0000_0010; vb[0] = 32'h0000_0020; vs[0] = 33'h0_0000_0030;
      va[1] = 32'h1234_5678; vb[1] = 32'h1111_1111; vs[1] = 33'h0_2345_6789;
      va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vs[2] = 33'h1_0000_0000;
      va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vs[3] = 33'h1_FFFF_FFFE;
      va[4] = 32'h0F0F_0F0F; vb[4] = 32'hF0F0_F0F0; vs[4] = 33'h0_FFFF_FFFF;
      va[5] = 32'hDEAD_BEEF; vb[5] = 32'h0000_0001; vs[5] = 33'h0_DEAD_BEF0;
      va[6] = 32'h7FFF_FFFF; vb[6] = 32'h0000_0001; vs[6] = 33'h0_8000_0000;
      va[7] = 32'hAAAA_AAAA; vb[7] = 32'h5555_5556; vs[7] = 33'h1_0000_0000;
      va[8] = 32'h0000_0100; vb[8] = 32'h0000_0200; vs[8] = 33'h0_0000_0300;
      va[9] = 32'hC000_0000; vb[9] = 32'h4000_0001; vs[9] = 33'h1_0000_0001;

      i_rst = 1'b1;
      i_valid = 1'b0;
      i_op1 = '0;
      i_op2 = '0;
      i_res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_valid", 64'(o_res_valid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_add_op", {o_add_op1, o_add_op2}, 64'd0);
      chk("rst_res", {31'd0, o_res_co, o_res_sum}, 64'd0);
      chk("rst_credits", 64'(dut.credits_q), 64'd4);
      i_rst = 1'b0;
      @(posedge clk); #1;

      // Single op latency
      i_res_ready = 1'b1;
      push(32'h1, 32'h2, 33'h3);
      chk("lat_c1_valid", 64'(o_res_valid), 64'd0);
      chk("issue_op", {o_add_op1, o_add_op2}, {32'h1, 32'h2});
      @(posedge clk); #1;
      chk("lat_c2_valid", 64'(o_res_valid), 64'd0);
      chk("lat_c2_busy", 64'(o_busy), 64'd1);
      @(posedge clk); #1;
      chk("lat_c3_valid", 64'(o_res_valid), 64'd1);
      chk("lat_c3_sum", 64'(o_res_sum), 64'h3);
      drain();

      // Streaming
      stream_on = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push(32'(i * 3 + 1), 32'(i * 5 + 2), 33'(i * 8 + 3));
      end
      stream_on = 1'b0;
      drain();
      chk("stream_ready_drop", 64'(ready_drop), 64'd0);
      chk("stream_run", 64'(max_run), 64'd16);

      // Wrap with carry
      push(32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
      drain();

      // Backpressure and credit corner cases
      i_res_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(va[i], vb[i], vs[i]);
      chk("bp_ready", 64'(o_ready), 64'd0);
      chk("bp_credits", 64'(dut.credits_q), 64'd0);
      chk("bp_valid", 64'(o_res_valid), 64'd1);
      chk("bp_no_issue", 64'(o_add_op1), 64'd0);
      i_res_ready = 1'b1;
      @(posedge clk); #1;
      chk("pop_no_issue_credits", 64'(dut.credits_q), 64'd1);
      chk("issue_head", 64'(o_add_op1), 64'(va[4]));
      @(posedge clk); #1;
      chk("pop_and_issue_credits", 64'(dut.credits_q), 64'd1);
      push(va[8], vb[8], vs[8]);
      push(va[9], vb[9], vs[9]);
      drain();

      // Reset mid-operation
      i_res_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(va[i], vb[i], vs[i]);
      i_rst = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_rst_valid", 64'(o_res_valid), 64'd0);
      chk("mid_rst_ready", 64'(o_ready), 64'd1);
      chk("mid_rst_busy", 64'(o_busy), 64'd0);
      @(posedge clk); #1;
      i_rst = 1'b0;
      i_res_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_busy", 64'(o_busy), 64'd0);
      chk("post_rst_credits", 64'(dut.credits_q), 64'd4);
      push(va[1], vb[1], vs[1]);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
